// File: rtl/alu_issue_pkg.sv
// Shared MIPS field layout, opcode/funct constants and ALU select codes
// for the ID/EX issue stage.
package alu_issue_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Every decoded op keeps bit 7 clear; the undefined code sets it.
    localparam logic [7:0] SELECT_ALU_ADD  = 8'h01;
    localparam logic [7:0] SELECT_ALU_SUB  = 8'h02;
    localparam logic [7:0] SELECT_ALU_AND  = 8'h03;
    localparam logic [7:0] SELECT_ALU_OR   = 8'h04;
    localparam logic [7:0] SELECT_ALU_XOR  = 8'h05;
    localparam logic [7:0] SELECT_ALU_NOR  = 8'h06;
    localparam logic [7:0] SELECT_ALU_SLT  = 8'h07;
    localparam logic [7:0] SELECT_ALU_SLTU = 8'h08;
    localparam logic [7:0] SELECT_ALU_SLL  = 8'h09;
    localparam logic [7:0] SELECT_ALU_SRL  = 8'h0A;
    localparam logic [7:0] SELECT_ALU_SRA  = 8'h0B;
    localparam logic [7:0] SELECT_ALU_SLLV = 8'h0C;
    localparam logic [7:0] SELECT_ALU_SRLV = 8'h0D;
    localparam logic [7:0] SELECT_ALU_SRAV = 8'h0E;
    localparam logic [7:0] SELECT_UNDEFINED = 8'hFF;

    typedef struct packed {
        logic [7:0]  sel;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// ALU operand/control bundle between the issue stage (master) and EX (slave).
interface alu_issue_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] RSbus;
  logic [31:0] RTbus;
  logic [31:0] Imm;
  logic        UseImm;
  logic [7:0]  SEL;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic [31:0] alu_result;

  modport master (
    output out_valid, RSbus, RTbus, Imm, UseImm, SEL, out_rd, out_wen, out_illegal,
    input  out_ready, alu_result
  );
  modport slave (
    input  out_valid, RSbus, RTbus, Imm, UseImm, SEL, out_rd, out_wen, out_illegal,
    output out_ready, alu_result
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Pure combinational decode of one MIPS word into the ALU control word.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = instr[OP_HI:OP_LO];
  assign funct    = instr[FN_HI:FN_LO];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  always_comb begin
    dec         = '0;
    dec.sel     = SELECT_UNDEFINED;
    dec.imm     = imm_sext;
    dec.use_imm = 1'b0;
    dec.rs      = instr[RS_HI:RS_LO];
    dec.rt      = instr[RT_HI:RT_LO];
    dec.rd      = instr[RT_HI:RT_LO];
    if (opcode == OP_RTYPE) begin
      dec.rd = instr[RD_HI:RD_LO];
      case (funct)
        FN_ADD, FN_ADDU: dec.sel = SELECT_ALU_ADD;
        FN_SUB, FN_SUBU: dec.sel = SELECT_ALU_SUB;
        FN_AND:          dec.sel = SELECT_ALU_AND;
        FN_OR:           dec.sel = SELECT_ALU_OR;
        FN_XOR:          dec.sel = SELECT_ALU_XOR;
        FN_NOR:          dec.sel = SELECT_ALU_NOR;
        FN_SLT:          dec.sel = SELECT_ALU_SLT;
        FN_SLTU:         dec.sel = SELECT_ALU_SLTU;
        // Constant shifts carry shamt in Imm[10:6] via the sign-extended low half.
        FN_SLL: begin dec.sel = SELECT_ALU_SLL; dec.use_imm = 1'b1; end
        FN_SRL: begin dec.sel = SELECT_ALU_SRL; dec.use_imm = 1'b1; end
        FN_SRA: begin dec.sel = SELECT_ALU_SRA; dec.use_imm = 1'b1; end
        FN_SLLV:         dec.sel = SELECT_ALU_SLLV;
        FN_SRLV:         dec.sel = SELECT_ALU_SRLV;
        FN_SRAV:         dec.sel = SELECT_ALU_SRAV;
        default:         dec.sel = SELECT_UNDEFINED;
      endcase
    end else begin
      dec.use_imm = 1'b1;
      case (opcode)
        OP_ADDI, OP_ADDIU: dec.sel = SELECT_ALU_ADD;
        OP_SLTI:           dec.sel = SELECT_ALU_SLT;
        OP_SLTIU:          dec.sel = SELECT_ALU_SLTU;
        OP_ANDI: begin dec.sel = SELECT_ALU_AND; dec.imm = imm_zext; end
        OP_ORI:  begin dec.sel = SELECT_ALU_OR;  dec.imm = imm_zext; end
        OP_XORI: begin dec.sel = SELECT_ALU_XOR; dec.imm = imm_zext; end
        default: begin dec.sel = SELECT_UNDEFINED; dec.use_imm = 1'b0; end
      endcase
    end
    dec.illegal = (dec.sel == SELECT_UNDEFINED);
    dec.wen     = !dec.illegal && (dec.rd != 5'd0);
  end
endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decode, operand resolution with WB/EX bypass, and the
// valid/ready register that drives the ALU inputs.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit FWD_EX = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  alu_issue_if.master alu
);
  dec_t        dec;
  logic        accept;
  logic        ex_fwd;
  logic        valid_reg;
  logic [31:0] rs_reg, rt_reg, imm_reg;
  logic        use_imm_reg, wen_reg, illegal_reg;
  logic [7:0]  sel_reg;
  logic [4:0]  rd_reg;

  alu_issue_decode u_decode (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = !valid_reg || alu.out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // Held result is only forwarded when it leaves on this very edge.
  assign ex_fwd   = FWD_EX && valid_reg && alu.out_ready && wen_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [4:0]  fld;
    logic [31:0] rf;
    logic [31:0] val;
    assign fld = (gi == 0) ? dec.rs : dec.rt;
    assign rf  = (gi == 0) ? rf_rs_data : rf_rt_data;
    always_comb begin
      val = rf;
      if (fld == 5'd0)                      val = '0;
      else if (ex_fwd && rd_reg == fld)     val = alu.alu_result;
      else if (wb_en && wb_addr == fld)     val = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      rs_reg      <= '0;
      rt_reg      <= '0;
      imm_reg     <= '0;
      use_imm_reg <= 1'b0;
      sel_reg     <= SELECT_UNDEFINED;
      rd_reg      <= '0;
      wen_reg     <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg   <= 1'b1;
      rs_reg      <= g_opnd[0].val;
      rt_reg      <= g_opnd[1].val;
      imm_reg     <= dec.imm;
      use_imm_reg <= dec.use_imm;
      sel_reg     <= dec.sel;
      rd_reg      <= dec.rd;
      wen_reg     <= dec.wen;
      illegal_reg <= dec.illegal;
    end else if (alu.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign alu.out_valid   = valid_reg;
  assign alu.RSbus       = rs_reg;
  assign alu.RTbus       = rt_reg;
  assign alu.Imm         = imm_reg;
  assign alu.UseImm      = use_imm_reg;
  assign alu.SEL         = sel_reg;
  assign alu.out_rd      = rd_reg;
  assign alu.out_wen     = wen_reg;
  assign alu.out_illegal = illegal_reg;
endmodule

// File: tb/tb_alu_issue.sv
// Table-driven bench for alu_issue with a scoreboard of issued control words.
module tb_alu_issue;
  import alu_issue_pkg::*;

  typedef struct {
    logic [31:0] rs, rt, imm;
    logic        use_imm;
    logic [7:0]  sel;
    logic [4:0]  rd;
    logic        wen, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr, rfs, rft;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, wb_en, flush;
  logic [31:0] in_instr, rf_rs_data, rf_rt_data, wb_data;
  logic [4:0]  wb_addr;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  vec_t        tbl[12];

  alu_issue_if bus();

  alu_issue #(.FWD_EX(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .rf_rs_data (rf_rs_data),
    .rf_rt_data (rf_rt_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush),
    .alu        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mke(logic [31:0] rs, logic [31:0] rt, logic [31:0] imm, logic ui,
                               logic [7:0] sel, logic [4:0] rd, logic wen, logic ill);
    exp_t e;
    e.rs = rs; e.rt = rt; e.imm = imm; e.use_imm = ui;
    e.sel = sel; e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mkv(logic [31:0] instr, logic [31:0] rfs, logic [31:0] rft,
                               logic wbe, logic [4:0] wba, logic [31:0] wbd, exp_t e);
    vec_t v;
    v.instr = instr; v.rfs = rfs; v.rft = rft;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.e = e;
    return v;
  endfunction

  // Scoreboard: an issued word is compared on the cycle EX takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.out_valid) begin
        if (flush) begin
          if (sb.size() > 0) e = sb.pop_front();
        end else if (bus.out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty actual=unexpected_issue required=none");
          end else begin
            e = sb.pop_front();
            $display("txn sel=%h rs=%h rt=%h imm=%h rd=%0d wen=%b ill=%b",
                     bus.SEL, bus.RSbus, bus.RTbus, bus.Imm, bus.out_rd, bus.out_wen,
                     bus.out_illegal);
            chk("RSbus", bus.RSbus, e.rs);
            chk("RTbus", bus.RTbus, e.rt);
            chk("SEL", {24'h0, bus.SEL}, {24'h0, e.sel});
            chk("out_wen", {31'h0, bus.out_wen}, {31'h0, e.wen});
            chk("out_illegal", {31'h0, bus.out_illegal}, {31'h0, e.ill});
            if (!e.ill) begin
              chk("UseImm", {31'h0, bus.UseImm}, {31'h0, e.use_imm});
              chk("out_rd", {27'h0, bus.out_rd}, {27'h0, e.rd});
              if (e.use_imm) chk("Imm", bus.Imm, e.imm);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mkv(32'h2022FFFF, 32'h5, 32'h7, 1'b0, 5'd0, 32'h0,
                  mke(32'h5, 32'h7, 32'hFFFFFFFF, 1'b1, SELECT_ALU_ADD, 5'd2, 1'b1, 1'b0));
    tbl[1]  = mkv(32'h34038001, 32'hDEAD, 32'h11, 1'b0, 5'd0, 32'h0,
                  mke(32'h0, 32'h11, 32'h00008001, 1'b1, SELECT_ALU_OR, 5'd3, 1'b1, 1'b0));
    tbl[2]  = mkv(32'h000520C0, 32'h77, 32'h40, 1'b0, 5'd0, 32'h0,
                  mke(32'h0, 32'h40, 32'h000020C0, 1'b1, SELECT_ALU_SLL, 5'd4, 1'b1, 1'b0));
    tbl[3]  = mkv(32'h00430820, 32'h10, 32'h20, 1'b1, 5'd3, 32'hCAFE,
                  mke(32'h10, 32'hCAFE, 32'h0, 1'b0, SELECT_ALU_ADD, 5'd1, 1'b1, 1'b0));
    tbl[4]  = mkv(32'h0022002A, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0,
                  mke(32'h3, 32'h4, 32'h0, 1'b0, SELECT_ALU_SLT, 5'd0, 1'b0, 1'b0));
    tbl[5]  = mkv(32'h3109F0F0, 32'h1111, 32'h2222, 1'b1, 5'd9, 32'h5555,
                  mke(32'h1111, 32'h5555, 32'h0000F0F0, 1'b1, SELECT_ALU_AND, 5'd9, 1'b1, 1'b0));
    tbl[6]  = mkv(32'h00A63807, 32'h3, 32'h80000000, 1'b0, 5'd0, 32'h0,
                  mke(32'h3, 32'h80000000, 32'h0, 1'b0, SELECT_ALU_SRAV, 5'd7, 1'b1, 1'b0));
    tbl[7]  = mkv(32'h2D6AFFFE, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
                  mke(32'h5, 32'h6, 32'hFFFFFFFE, 1'b1, SELECT_ALU_SLTU, 5'd10, 1'b1, 1'b0));
    tbl[8]  = mkv(32'hFC221234, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                  mke(32'h1, 32'h2, 32'h0, 1'b0, SELECT_UNDEFINED, 5'd0, 1'b0, 1'b1));
    tbl[9]  = mkv(32'h00430801, 32'hA, 32'hB, 1'b0, 5'd0, 32'h0,
                  mke(32'hA, 32'hB, 32'h0, 1'b0, SELECT_UNDEFINED, 5'd0, 1'b0, 1'b1));
    tbl[10] = mkv(32'h380C8000, 32'hDEAD, 32'h44, 1'b1, 5'd0, 32'h9,
                  mke(32'h0, 32'h44, 32'h00008000, 1'b1, SELECT_ALU_XOR, 5'd12, 1'b1, 1'b0));
    tbl[11] = mkv(32'h01CF6827, 32'h12345678, 32'h0F0F0F0F, 1'b1, 5'd14, 32'h77,
                  mke(32'h77, 32'h0F0F0F0F, 32'h0, 1'b0, SELECT_ALU_NOR, 5'd13, 1'b1, 1'b0));

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; rf_rs_data = '0; rf_rt_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    bus.out_ready = 1'b1; bus.alu_result = 32'hBAD00000;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_SEL", {24'h0, bus.SEL}, {24'h0, SELECT_UNDEFINED});
    chk("rst_RSbus", bus.RSbus, 32'h0);
    chk("rst_RTbus", bus.RTbus, 32'h0);
    chk("rst_Imm", bus.Imm, 32'h0);
    chk("rst_flags", {28'h0, bus.UseImm, bus.out_wen, bus.out_illegal, 1'b0}, 32'h0);
    chk("rst_out_rd", {27'h0, bus.out_rd}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Each vector followed by a bubble so no EX forward is in play.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = tbl[i].instr;
      rf_rs_data = tbl[i].rfs; rf_rt_data = tbl[i].rft;
      wb_en = tbl[i].wbe; wb_addr = tbl[i].wba; wb_data = tbl[i].wbd;
      sb.push_back(tbl[i].e);
      @(negedge clk);
      in_valid = 1'b0; wb_en = 1'b0;
    end

    // Back-to-back: add r2 leaves while sub r6,r2,r2 is accepted.
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00211020; rf_rs_data = 32'h3; rf_rt_data = 32'h3;
    sb.push_back(mke(32'h3, 32'h3, 32'h0, 1'b0, SELECT_ALU_ADD, 5'd2, 1'b1, 1'b0));
    @(negedge clk);
    in_instr = 32'h00423022; rf_rs_data = 32'h55; rf_rt_data = 32'h55;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h99; bus.alu_result = 32'h1234;
    sb.push_back(mke(32'h1234, 32'h1234, 32'h0, 1'b0, SELECT_ALU_SUB, 5'd6, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b0; bus.alu_result = 32'hBAD00000;
    @(negedge clk);

    // Stall for three cycles with a competing instruction, then flush.
    in_valid = 1'b1; in_instr = 32'h00430820; rf_rs_data = 32'h10; rf_rt_data = 32'h20;
    sb.push_back(mke(32'h10, 32'h20, 32'h0, 1'b0, SELECT_ALU_ADD, 5'd1, 1'b1, 1'b0));
    @(negedge clk);
    bus.out_ready = 1'b0; in_instr = 32'h2022FFFF; rf_rs_data = 32'h5; rf_rt_data = 32'h6;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("stall_RSbus", bus.RSbus, 32'h10);
      chk("stall_RTbus", bus.RTbus, 32'h20);
      chk("stall_SEL", {24'h0, bus.SEL}, {24'h0, SELECT_ALU_ADD});
      @(negedge clk);
    end
    flush = 1'b1;
    #2;
    chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #2;
    chk("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("flush_in_ready2", {31'h0, in_ready}, 32'h1);

    // Reset while holding: asynchronous clear.
    @(negedge clk);
    bus.out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00430820;
    sb.push_back(mke(32'h10, 32'h20, 32'h0, 1'b0, SELECT_ALU_ADD, 5'd1, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_SEL", {24'h0, bus.SEL}, {24'h0, SELECT_UNDEFINED});
    chk("arst_out_wen", {31'h0, bus.out_wen}, 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
    bus.out_ready = 1'b1;

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    chk("sb_drain", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
